// File: rtl/regs_arb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package regs_arb_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int REG_AW_DEF   = 5;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_EX   = 2'd1,
    GNT_LSU  = 2'd2
  } gnt_e;

endpackage

// File: rtl/regs_scoreboard.sv
// Busy-bit scoreboard for outstanding loads; one set port, one clear port,
// two combinational lookups. Register 0 is never reported busy.
module regs_scoreboard
  import regs_arb_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] rd0_addr,
  input  logic [REG_AW-1:0] rd1_addr,
  output logic              rd0_busy,
  output logic              rd1_busy
);

  localparam int NREG = 2 ** REG_AW;

  logic [NREG-1:0] busy;

  // Set is written after clear so a same-cycle reissue keeps the bit set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en && (set_addr != '0)) busy[set_addr] <= 1'b1;
    end
  end

  assign rd0_busy = busy[rd0_addr] && (rd0_addr != '0);
  assign rd1_busy = busy[rd1_addr] && (rd1_addr != '0);

endmodule

// File: rtl/regs_wb_arbiter.sv
// EX/LSU writeback arbiter with LSU starvation guard and load scoreboard.
// Optional perf counters enabled by REGS_WB_ARB_PERF_EN.
module regs_wb_arbiter
  import regs_arb_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int REG_AW       = REG_AW_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [REG_AW-1:0] ex_waddr_i,
  input  logic [XLEN-1:0]   ex_wdata_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [REG_AW-1:0] lsu_waddr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  input  logic              lsu_issue_i,
  input  logic [REG_AW-1:0] lsu_issue_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  output logic              id_stall_o,
  output logic              reg_wen_o,
  output logic [REG_AW-1:0] reg_waddr_o,
  output logic [XLEN-1:0]   reg_wdata_o
`ifdef REGS_WB_ARB_PERF_EN
  ,
  output logic [31:0]       perf_ex_block_o,
  output logic [31:0]       perf_stall_o
`endif
);

  gnt_e                    gnt;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    starve_hit;
  logic                    rs1_busy;
  logic                    rs2_busy;

  assign starve_hit = (starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));

  always_comb begin
    gnt = GNT_NONE;
    if (rst) begin
      if (lsu_valid_i && starve_hit) gnt = GNT_LSU;
      else if (ex_valid_i)           gnt = GNT_EX;
      else if (lsu_valid_i)          gnt = GNT_LSU;
    end
  end

  assign ex_ready_o  = (gnt == GNT_EX);
  assign lsu_ready_o = (gnt == GNT_LSU);

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!lsu_valid_i || (gnt == GNT_LSU)) begin
      starve_cnt <= '0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Writes to x0 are accepted and consumed but never enable the port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_wen_o   <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
    end else begin
      case (gnt)
        GNT_EX: begin
          reg_wen_o   <= (ex_waddr_i != '0);
          reg_waddr_o <= ex_waddr_i;
          reg_wdata_o <= ex_wdata_i;
        end
        GNT_LSU: begin
          reg_wen_o   <= (lsu_waddr_i != '0);
          reg_waddr_o <= lsu_waddr_i;
          reg_wdata_o <= lsu_wdata_i;
        end
        default: reg_wen_o <= 1'b0;
      endcase
    end
  end

  regs_scoreboard #(
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (lsu_issue_i),
    .set_addr (lsu_issue_rd_i),
    .clr_en   (gnt == GNT_LSU),
    .clr_addr (lsu_waddr_i),
    .rd0_addr (id_rs1_i),
    .rd1_addr (id_rs2_i),
    .rd0_busy (rs1_busy),
    .rd1_busy (rs2_busy)
  );

  assign id_stall_o = rst && (rs1_busy || rs2_busy);

`ifdef REGS_WB_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_ex_block_o <= '0;
      perf_stall_o    <= '0;
    end else begin
      if (ex_valid_i && !ex_ready_o) perf_ex_block_o <= perf_ex_block_o + 32'd1;
      if (id_stall_o)                perf_stall_o    <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench for regs_wb_arbiter; perf checks compiled in with REGS_WB_ARB_PERF_EN.
module tb_regs_wb_arbiter;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid_i, ex_ready_o;
  logic [REG_AW-1:0] ex_waddr_i;
  logic [XLEN-1:0]   ex_wdata_i;
  logic              lsu_valid_i, lsu_ready_o;
  logic [REG_AW-1:0] lsu_waddr_i;
  logic [XLEN-1:0]   lsu_wdata_i;
  logic              lsu_issue_i;
  logic [REG_AW-1:0] lsu_issue_rd_i;
  logic [REG_AW-1:0] id_rs1_i, id_rs2_i;
  logic              id_stall_o;
  logic              reg_wen_o;
  logic [REG_AW-1:0] reg_waddr_o;
  logic [XLEN-1:0]   reg_wdata_o;
`ifdef REGS_WB_ARB_PERF_EN
  logic [31:0]       perf_ex_block_o, perf_stall_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  regs_wb_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW), .STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid_i     (ex_valid_i),
    .ex_ready_o     (ex_ready_o),
    .ex_waddr_i     (ex_waddr_i),
    .ex_wdata_i     (ex_wdata_i),
    .lsu_valid_i    (lsu_valid_i),
    .lsu_ready_o    (lsu_ready_o),
    .lsu_waddr_i    (lsu_waddr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_issue_i    (lsu_issue_i),
    .lsu_issue_rd_i (lsu_issue_rd_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_stall_o     (id_stall_o),
    .reg_wen_o      (reg_wen_o),
    .reg_waddr_o    (reg_waddr_o),
    .reg_wdata_o    (reg_wdata_o)
`ifdef REGS_WB_ARB_PERF_EN
    ,
    .perf_ex_block_o (perf_ex_block_o),
    .perf_stall_o    (perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid_i  = 1'b0;
    lsu_valid_i = 1'b0;
    lsu_issue_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ex_valid_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'h0000_0011;
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd4; lsu_wdata_i = 32'h0000_0022;
    lsu_issue_i = 1'b0; lsu_issue_rd_i = '0;
    id_rs1_i = 5'd3; id_rs2_i = 5'd4;
    tick(); tick();
    #1;
    n_vec++; if (ex_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_ex_ready got %b exp 0", ex_ready_o); end
    n_vec++; if (lsu_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_lsu_ready got %b exp 0", lsu_ready_o); end
    n_vec++; if (id_stall_o !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", id_stall_o); end
    n_vec++; if (reg_wen_o !== 1'b0) begin n_err++; $display("FAIL rst_wen got %b exp 0", reg_wen_o); end
    n_vec++; if (reg_waddr_o !== 5'd0) begin n_err++; $display("FAIL rst_waddr got %0d exp 0", reg_waddr_o); end
    n_vec++; if (reg_wdata_o !== 32'd0) begin n_err++; $display("FAIL rst_wdata got %h exp 0", reg_wdata_o); end
    rst = 1'b1;
    #1;
    n_vec++; if (ex_ready_o !== 1'b1) begin n_err++; $display("FAIL rel_ex_ready got %b exp 1", ex_ready_o); end
    n_vec++; if (lsu_ready_o !== 1'b0) begin n_err++; $display("FAIL rel_lsu_ready got %b exp 0", lsu_ready_o); end
    tick();
    idle();
    n_vec++; if (reg_wen_o !== 1'b1) begin n_err++; $display("FAIL rel_wen got %b exp 1", reg_wen_o); end
    n_vec++; if (reg_waddr_o !== 5'd3) begin n_err++; $display("FAIL rel_waddr got %0d exp 3", reg_waddr_o); end
    n_vec++; if (reg_wdata_o !== 32'h11) begin n_err++; $display("FAIL rel_wdata got %h exp 11", reg_wdata_o); end
    tick();
    n_vec++; if (reg_wen_o !== 1'b0) begin n_err++; $display("FAIL idle_wen got %b exp 0", reg_wen_o); end
    n_vec++; if (reg_waddr_o !== 5'd3) begin n_err++; $display("FAIL idle_waddr_hold got %0d exp 3", reg_waddr_o); end
    n_vec++; if (reg_wdata_o !== 32'h11) begin n_err++; $display("FAIL idle_wdata_hold got %h exp 11", reg_wdata_o); end
  endtask

  task automatic test_contention();
    logic        exp_lsu;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    for (int k = 0; k < 6; k++) begin
      ex_valid_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 32'h100 + k;
      lsu_valid_i = 1'b1; lsu_waddr_i = 5'd2; lsu_wdata_i = 32'h200 + k;
      #1;
      exp_lsu  = (k == 4);
      exp_addr = exp_lsu ? 5'd2 : 5'd1;
      exp_data = exp_lsu ? (32'h200 + k) : (32'h100 + k);
      n_vec++; if (ex_ready_o !== !exp_lsu) begin n_err++; $display("FAIL cont_ex_ready[%0d] got %b exp %b", k, ex_ready_o, !exp_lsu); end
      n_vec++; if (lsu_ready_o !== exp_lsu) begin n_err++; $display("FAIL cont_lsu_ready[%0d] got %b exp %b", k, lsu_ready_o, exp_lsu); end
      tick();
      n_vec++; if (reg_wen_o !== 1'b1) begin n_err++; $display("FAIL cont_wen[%0d] got %b exp 1", k, reg_wen_o); end
      n_vec++; if (reg_waddr_o !== exp_addr) begin n_err++; $display("FAIL cont_waddr[%0d] got %0d exp %0d", k, reg_waddr_o, exp_addr); end
      n_vec++; if (reg_wdata_o !== exp_data) begin n_err++; $display("FAIL cont_wdata[%0d] got %h exp %h", k, reg_wdata_o, exp_data); end
    end
    idle();
    tick();
  endtask

  // LSU drops out for one cycle, which must restart its starvation count.
  task automatic test_starve_clear();
    logic [8:0] lsu_pat;
    logic       exp_lsu;
    lsu_pat = 9'b1_1111_0111;
    for (int k = 0; k < 9; k++) begin
      ex_valid_i = 1'b1; ex_waddr_i = 5'd10; ex_wdata_i = 32'hA0 + k;
      lsu_valid_i = lsu_pat[k]; lsu_waddr_i = 5'd11; lsu_wdata_i = 32'hB0 + k;
      #1;
      exp_lsu = (k == 8);
      n_vec++; if (ex_ready_o !== !exp_lsu) begin n_err++; $display("FAIL sclr_ex_ready[%0d] got %b exp %b", k, ex_ready_o, !exp_lsu); end
      n_vec++; if (lsu_ready_o !== exp_lsu) begin n_err++; $display("FAIL sclr_lsu_ready[%0d] got %b exp %b", k, lsu_ready_o, exp_lsu); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_load_stall();
    id_rs1_i = 5'd5; id_rs2_i = 5'd0;
    lsu_issue_i = 1'b1; lsu_issue_rd_i = 5'd5;
    #1;
    n_vec++; if (id_stall_o !== 1'b0) begin n_err++; $display("FAIL ld_stall_pre got %b exp 0", id_stall_o); end
    tick();
    lsu_issue_i = 1'b0;
    #1;
    n_vec++; if (id_stall_o !== 1'b1) begin n_err++; $display("FAIL ld_stall_busy got %b exp 1", id_stall_o); end
    tick();
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd5; lsu_wdata_i = 32'h0000_CAFE;
    #1;
    n_vec++; if (lsu_ready_o !== 1'b1) begin n_err++; $display("FAIL ld_lsu_ready got %b exp 1", lsu_ready_o); end
    n_vec++; if (id_stall_o !== 1'b1) begin n_err++; $display("FAIL ld_stall_grant got %b exp 1", id_stall_o); end
    tick();
    lsu_valid_i = 1'b0;
    #1;
    n_vec++; if (id_stall_o !== 1'b0) begin n_err++; $display("FAIL ld_stall_after got %b exp 0", id_stall_o); end
    n_vec++; if (reg_wen_o !== 1'b1) begin n_err++; $display("FAIL ld_wen got %b exp 1", reg_wen_o); end
    n_vec++; if (reg_waddr_o !== 5'd5) begin n_err++; $display("FAIL ld_waddr got %0d exp 5", reg_waddr_o); end
    n_vec++; if (reg_wdata_o !== 32'hCAFE) begin n_err++; $display("FAIL ld_wdata got %h exp cafe", reg_wdata_o); end
    tick();
  endtask

  task automatic test_same_cycle();
    id_rs1_i = 5'd0; id_rs2_i = 5'd7;
    lsu_issue_i = 1'b1; lsu_issue_rd_i = 5'd7;
    tick();
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'h77;
    #1;
    n_vec++; if (lsu_ready_o !== 1'b1) begin n_err++; $display("FAIL sc_lsu_ready got %b exp 1", lsu_ready_o); end
    tick();
    idle();
    #1;
    n_vec++; if (id_stall_o !== 1'b1) begin n_err++; $display("FAIL sc_stall_kept got %b exp 1", id_stall_o); end
    n_vec++; if (reg_waddr_o !== 5'd7) begin n_err++; $display("FAIL sc_waddr got %0d exp 7", reg_waddr_o); end
    tick();
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'h78;
    tick();
    idle();
    #1;
    n_vec++; if (id_stall_o !== 1'b0) begin n_err++; $display("FAIL sc_stall_cleared got %b exp 0", id_stall_o); end
    tick();
  endtask

  task automatic test_reg0();
    ex_valid_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hDEAD_BEEF;
    lsu_issue_i = 1'b1; lsu_issue_rd_i = 5'd0;
    id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    #1;
    n_vec++; if (ex_ready_o !== 1'b1) begin n_err++; $display("FAIL r0_ex_ready got %b exp 1", ex_ready_o); end
    tick();
    idle();
    #1;
    n_vec++; if (reg_wen_o !== 1'b0) begin n_err++; $display("FAIL r0_wen got %b exp 0", reg_wen_o); end
    n_vec++; if (id_stall_o !== 1'b0) begin n_err++; $display("FAIL r0_stall got %b exp 0", id_stall_o); end
    tick();
  endtask

  task automatic test_reset_busy();
    lsu_issue_i = 1'b1; lsu_issue_rd_i = 5'd9;
    id_rs1_i = 5'd9; id_rs2_i = 5'd0;
    tick();
    lsu_issue_i = 1'b0;
    #1;
    n_vec++; if (id_stall_o !== 1'b1) begin n_err++; $display("FAIL rb_stall_set got %b exp 1", id_stall_o); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_vec++; if (id_stall_o !== 1'b0) begin n_err++; $display("FAIL rb_stall_cleared got %b exp 0", id_stall_o); end
    tick();
  endtask

`ifdef REGS_WB_ARB_PERF_EN
  task automatic test_perf();
    idle();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ex_valid_i = 1'b1; ex_waddr_i = 5'd12; ex_wdata_i = 32'h300 + k;
      lsu_valid_i = 1'b1; lsu_waddr_i = 5'd13; lsu_wdata_i = 32'h400 + k;
      tick();
    end
    idle();
    tick();
    n_vec++; if (perf_ex_block_o !== 32'd2) begin n_err++; $display("FAIL perf_ex_block got %0d exp 2", perf_ex_block_o); end
    n_vec++; if (perf_stall_o !== 32'd0) begin n_err++; $display("FAIL perf_stall got %0d exp 0", perf_stall_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_starve_clear();
    test_load_stall();
    test_same_cycle();
    test_reg0();
    test_reset_busy();
`ifdef REGS_WB_ARB_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: the execute unit (EX) and the load/store unit (LSU).
- Keeps a per-register busy scoreboard for outstanding loads and raises a stall to decode when a source operand is still pending.
- Sits between EX/LSU writeback and the register file write port (reg_waddr_i / reg_wdata_i / reg_wen).

Parameters:
- XLEN, 32, data width of the write port.
- REG_AW, 5, register address width; 2**REG_AW registers, register 0 hard-wired to zero.
- STARVE_LIMIT, 4, consecutive LSU-denied cycles before LSU is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- ex_valid_i  in  1  EX writeback request.
- ex_ready_o  out  1  EX request accepted this cycle.
- ex_waddr_i  in  REG_AW  EX destination register.
- ex_wdata_i  in  XLEN  EX writeback data.
- lsu_valid_i  in  1  LSU writeback request.
- lsu_ready_o  out  1  LSU request accepted this cycle.
- lsu_waddr_i  in  REG_AW  LSU destination register.
- lsu_wdata_i  in  XLEN  LSU load data.
- lsu_issue_i  in  1  load issued; marks its destination register busy.
- lsu_issue_rd_i  in  REG_AW  destination register of the issued load.
- id_rs1_i  in  REG_AW  decode source register 1.
- id_rs2_i  in  REG_AW  decode source register 2.
- id_stall_o  out  1  decode must hold; a source register is busy.
- reg_wen_o  out  1  register file write enable.
- reg_waddr_o  out  REG_AW  register file write address.
- reg_wdata_o  out  XLEN  register file write data.

Behaviour:
- Reset (rst==0 at posedge):
  - reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0.
  - All busy bits cleared; starvation counter cleared.
  - ex_ready_o, lsu_ready_o and id_stall_o read 0 while rst==0.
  - Reset mid-operation drops any accepted-but-not-yet-driven write.
- Handshake:
  - A transfer occurs when valid and ready are both 1 in the same cycle.
  - ready is combinational from the valids and the starvation counter.
  - Exactly one requester may be granted per cycle.
- Arbitration:
  - Default priority goes to EX.
  - If starve_cnt==STARVE_LIMIT and lsu_valid_i==1, LSU wins and ex_ready_o=0.
  - If only one requester is valid, that requester is granted.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle LSU is valid and not granted.
  - Clears on an LSU grant or whenever lsu_valid_i==0.
- Write port:
  - Registered. A grant in cycle N drives reg_wen_o/addr/data in cycle N+1.
  - With no grant, reg_wen_o=0 in N+1 and addr/data hold their previous values.
  - A granted write to register 0 is accepted (ready=1) but drives reg_wen_o=0.
- Scoreboard:
  - lsu_issue_i with rd!=0 sets busy[rd] at the next edge; rd==0 is ignored.
  - An LSU grant clears busy[lsu_waddr_i] at the next edge.
  - Set and clear of the same register in the same cycle: set wins (a new load is outstanding).
  - An EX grant never touches busy bits.
- Stall:
  - id_stall_o = (busy[id_rs1_i] && id_rs1_i!=0) || (busy[id_rs2_i] && id_rs2_i!=0). Combinational, zero latency.
  - The register file forwards its write port, so a register whose LSU write is on reg_w* in the current cycle is already not busy.
- Illegal stimulus: lsu_issue_i to an already-busy register has no extra effect; the busy bit stays set.

Optional Feature:
- Macro: REGS_WB_ARB_PERF_EN.
- When defined:
  - Adds outputs perf_ex_block_o[31:0] and perf_stall_o[31:0].
  - perf_ex_block_o counts cycles where ex_valid_i==1 and ex_ready_o==0.
  - perf_stall_o counts id_stall_o cycles.
  - Both counters are free-running, wrap modulo 2^32, and clear on reset.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package regs_arb_pkg:
  - XLEN and REG_AW defaults.
  - Grant encoding typedef: GNT_NONE, GNT_EX, GNT_LSU.
  - STARVE_CNT_W=4.
- Sub-module regs_scoreboard:
  - Holds the busy vector with set/clear ports and two combinational lookup ports.
  - Instantiated once.
- The arbiter, starvation counter and write-port register stay in the top module.

Test Plan:
- Reset: hold rst=0 with both valids=1 -> ready_o=0, reg_wen_o=0. Release rst -> EX is granted in the first cycle and reg_wen_o=1 one cycle later with EX addr/data.
- Contention: EX and LSU valid continuously, STARVE_LIMIT=4 -> EX granted for 4 cycles, LSU granted in the 5th, EX resumes in the 6th. Verify the write port carries each value in order at N+1.
- Load stall: issue rd=5, then id_rs1_i=5 -> id_stall_o=1. LSU writeback to x5 is granted in cycle N -> id_stall_o=0 from cycle N+1 and reg_waddr_o=5, reg_wen_o=1 in N+1.
- Same-cycle set/clear: LSU grant to x7 in the same cycle as lsu_issue_i rd=7 -> busy[7] stays 1 and id_rs2_i=7 still stalls.
- Register 0: EX writes x0 with data 0xDEADBEEF and lsu_issue_rd_i=0 -> ex_ready_o=1, reg_wen_o=0, and id_rs1_i=0 never stalls.
- Perf build (REGS_WB_ARB_PERF_EN): 10 cycles of contention with STARVE_LIMIT=4 -> perf_ex_block_o=2.
